// File: rtl/store_op_issuer.sv
// rtl/store_op_issuer.sv - store operand stream transmitter with instruction beat tracking
module store_op_issuer #(
   parameter int DataDepth    = 4,
   parameter int InsnDepth    = 2,
   parameter int BeatCntWidth = 8,
   parameter int IdWidth      = 4,
   parameter int DataWidth    = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic                    insn_valid_i,
   output logic                    insn_ready_o,
   input  logic [IdWidth-1:0]      insn_id_i,
   input  logic [BeatCntWidth-1:0] beat_cnt_i,
   input  logic                    data_valid_i,
   output logic                    data_ready_o,
   input  logic [DataWidth-1:0]    data_i,
   output logic                    store_op_valid_o,
   output logic [DataWidth-1:0]    store_op_o,
   input  logic                    store_op_gnt_i,
   output logic                    done_o,
   output logic [IdWidth-1:0]      done_insn_id_o
);

   localparam int DPW = $clog2(DataDepth);
   localparam int IPW = $clog2(InsnDepth);
   localparam int DCW = DPW + 1;
   localparam int ICW = IPW + 1;
   localparam logic [DCW-1:0] DataFull = DCW'(DataDepth);
   localparam logic [ICW-1:0] InsnFull = ICW'(InsnDepth);

   // data FIFO state
   logic [DataWidth-1:0]    dmem_q [DataDepth];
   logic [DataWidth-1:0]    dmem_d [DataDepth];
   logic [DPW-1:0]          dwr_q, dwr_d, drd_q, drd_d;
   logic [DCW-1:0]          dcnt_q, dcnt_d;

   // instruction queue state; the count field of the head entry is decremented in place
   logic [IdWidth-1:0]      iid_q [InsnDepth];
   logic [IdWidth-1:0]      iid_d [InsnDepth];
   logic [BeatCntWidth-1:0] irem_q [InsnDepth];
   logic [BeatCntWidth-1:0] irem_d [InsnDepth];
   logic [IPW-1:0]          iwr_q, iwr_d, ird_q, ird_d;
   logic [ICW-1:0]          icnt_q, icnt_d;

   // completion report
   logic                    done_q, done_d;
   logic [IdWidth-1:0]      done_id_q, done_id_d;

   // control decode
   logic                    data_full, data_empty, insn_full, insn_empty;
   logic                    data_push, insn_push, fire, insn_pop;
   logic [BeatCntWidth-1:0] head_rem;
   logic [IdWidth-1:0]      head_id;

   // status flags, output stream and handshake decode, all from registered state plus inputs
   always_comb begin
      data_full        = (dcnt_q == DataFull);
      data_empty       = (dcnt_q == '0);
      insn_full        = (icnt_q == InsnFull);
      insn_empty       = (icnt_q == '0);
      head_rem         = irem_q[ird_q];
      head_id          = iid_q[ird_q];
      insn_ready_o     = !insn_full;
      data_ready_o     = !data_full;
      store_op_valid_o = !data_empty && !insn_empty && (head_rem != '0);
      store_op_o       = data_empty ? '0 : dmem_q[drd_q];
      data_push        = data_valid_i && !data_full;
      insn_push        = insn_valid_i && !insn_full;
      // a grant without valid is dropped here
      fire             = store_op_gnt_i && store_op_valid_o;
      // zero-beat heads retire immediately; others retire on their last granted beat
      insn_pop         = !insn_empty && ((head_rem == '0) ||
                                         (fire && (head_rem == BeatCntWidth'(1))));
   end

   // data FIFO next state; flush discards contents and same-cycle push/pop
   always_comb begin
      dmem_d = dmem_q;
      dwr_d  = dwr_q;
      drd_d  = drd_q;
      dcnt_d = dcnt_q;
      if (flush_i) begin
         dwr_d  = '0;
         drd_d  = '0;
         dcnt_d = '0;
      end else begin
         if (data_push) begin
            dmem_d[dwr_q] = data_i;
            dwr_d         = dwr_q + 1'b1;
         end
         if (fire) begin
            drd_d = drd_q + 1'b1;
         end
         case ({data_push, fire})
            2'b10:   dcnt_d = dcnt_q + 1'b1;
            2'b01:   dcnt_d = dcnt_q - 1'b1;
            default: dcnt_d = dcnt_q;
         endcase
      end
   end

   // instruction queue next state; head count decrements on every granted beat
   always_comb begin
      iid_d  = iid_q;
      irem_d = irem_q;
      iwr_d  = iwr_q;
      ird_d  = ird_q;
      icnt_d = icnt_q;
      if (flush_i) begin
         iwr_d  = '0;
         ird_d  = '0;
         icnt_d = '0;
      end else begin
         // push slot never aliases the head: equal pointers mean empty (no head) or full (no push)
         if (insn_push) begin
            iid_d[iwr_q]  = insn_id_i;
            irem_d[iwr_q] = beat_cnt_i;
            iwr_d         = iwr_q + 1'b1;
         end
         if (fire) begin
            irem_d[ird_q] = head_rem - 1'b1;
         end
         if (insn_pop) begin
            ird_d = ird_q + 1'b1;
         end
         case ({insn_push, insn_pop})
            2'b10:   icnt_d = icnt_q + 1'b1;
            2'b01:   icnt_d = icnt_q - 1'b1;
            default: icnt_d = icnt_q;
         endcase
      end
   end

   // completion pulse one cycle after the retiring edge, suppressed by flush
   always_comb begin
      done_d    = insn_pop && !flush_i;
      done_id_d = done_id_q;
      if (insn_pop && !flush_i) begin
         done_id_d = head_id;
      end
   end

   assign done_o         = done_q;
   assign done_insn_id_o = done_id_q;

   // state registers with asynchronous clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DataDepth; i++) begin
            dmem_q[i] <= '0;
         end
         for (int i = 0; i < InsnDepth; i++) begin
            iid_q[i]  <= '0;
            irem_q[i] <= '0;
         end
         dwr_q     <= '0;
         drd_q     <= '0;
         dcnt_q    <= '0;
         iwr_q     <= '0;
         ird_q     <= '0;
         icnt_q    <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
      end else begin
         dmem_q    <= dmem_d;
         iid_q     <= iid_d;
         irem_q    <= irem_d;
         dwr_q     <= dwr_d;
         drd_q     <= drd_d;
         dcnt_q    <= dcnt_d;
         iwr_q     <= iwr_d;
         ird_q     <= ird_d;
         icnt_q    <= icnt_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
      end
   end

endmodule

// File: tb/tb_store_op_issuer.sv
// tb/tb_store_op_issuer.sv - scoreboard bench for store_op_issuer
module tb_store_op_issuer;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        insn_valid;
   logic        insn_ready;
   logic [3:0]  insn_id;
   logic [7:0]  beat_cnt;
   logic        data_valid;
   logic        data_ready;
   logic [31:0] data;
   logic        store_op_valid;
   logic [31:0] store_op;
   logic        store_op_gnt;
   logic        done;
   logic [3:0]  done_id;
   logic        gnt_en;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] exp_data [$];
   logic [3:0]  exp_done [$];
   int          done_cycles [$];
   int          gnt_cycles [$];
   int          last_gnt_cyc = 0;
   int          last_done_cyc = 0;

   // downstream only grants while a beat is offered
   assign store_op_gnt = gnt_en & store_op_valid;

   store_op_issuer dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .flush_i          (flush),
      .insn_valid_i     (insn_valid),
      .insn_ready_o     (insn_ready),
      .insn_id_i        (insn_id),
      .beat_cnt_i       (beat_cnt),
      .data_valid_i     (data_valid),
      .data_ready_o     (data_ready),
      .data_i           (data),
      .store_op_valid_o (store_op_valid),
      .store_op_o       (store_op),
      .store_op_gnt_i   (store_op_gnt),
      .done_o           (done),
      .done_insn_id_o   (done_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard: compare granted beats and completions against what was pushed
   always @(negedge clk) begin
      if (rst_n) begin
         if (store_op_valid && store_op_gnt) begin
            gnt_cycles.push_back(cyc);
            last_gnt_cyc = cyc;
            if (exp_data.size() == 0) check("beat_unexpected", store_op, 32'hdead_beef);
            else check("beat", store_op, exp_data.pop_front());
         end
         if (done) begin
            done_cycles.push_back(cyc);
            last_done_cyc = cyc;
            if (exp_done.size() == 0) check("done_unexpected", 32'(done_id), 32'hff);
            else check("done_id", 32'(done_id), 32'(exp_done.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_insn(input logic [3:0] id, input logic [7:0] cnt);
      insn_valid = 1'b1;
      insn_id    = id;
      beat_cnt   = cnt;
      for (int n = 0; n < 50; n++) begin
         if (insn_ready) begin
            tick();
            insn_valid = 1'b0;
            exp_done.push_back(id);
            return;
         end
         tick();
      end
      insn_valid = 1'b0;
      check("insn_push_timeout", 32'd1, 32'd0);
   endtask

   task automatic push_data(input logic [31:0] d);
      data_valid = 1'b1;
      data       = d;
      for (int n = 0; n < 50; n++) begin
         if (data_ready) begin
            tick();
            data_valid = 1'b0;
            exp_data.push_back(d);
            return;
         end
         tick();
      end
      data_valid = 1'b0;
      check("data_push_timeout", 32'd1, 32'd0);
   endtask

   task automatic drain();
      for (int n = 0; n < 200; n++) begin
         if (exp_data.size() == 0 && exp_done.size() == 0) break;
         tick();
      end
      check("drain_left", 32'(exp_data.size() + exp_done.size()), 32'd0);
      tick();
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      gnt_en = 1'b0;
      exp_data.delete();
      exp_done.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      flush      = 1'b0;
      insn_valid = 1'b0;
      insn_id    = '0;
      beat_cnt   = '0;
      data_valid = 1'b0;
      data       = '0;
      gnt_en     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(store_op_valid), 32'd0);
      check("rst_op", store_op, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_done_id", 32'(done_id), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rst_insn_ready", 32'(insn_ready), 32'd1);
      check("rst_data_ready", 32'(data_ready), 32'd1);

      // basic two-beat instruction
      gnt_cycles.delete();
      push_insn(4'd3, 8'd2);
      push_data(32'hA);
      push_data(32'hB);
      gnt_en = 1'b1;
      drain();
      gnt_en = 1'b0;
      check("basic_gnt_count", 32'(gnt_cycles.size()), 32'd2);
      check("basic_consecutive", 32'(gnt_cycles[1] - gnt_cycles[0]), 32'd1);
      check("basic_done_latency", 32'(last_done_cyc - last_gnt_cyc), 32'd1);

      // backpressure with full data FIFO
      for (int i = 0; i < 4; i++) push_data(32'hC0 + 32'(i));
      check("bp_data_ready", 32'(data_ready), 32'd0);
      check("bp_op_head", store_op, 32'hC0);
      check("bp_valid_no_insn", 32'(store_op_valid), 32'd0);
      push_insn(4'd8, 8'd4);
      check("bp_valid", 32'(store_op_valid), 32'd1);
      check("bp_op_stable", store_op, 32'hC0);
      gnt_en = 1'b1;
      tick();
      gnt_en = 1'b0;
      check("bp_data_ready_back", 32'(data_ready), 32'd1);
      check("bp_op_next", store_op, 32'hC1);
      gnt_en = 1'b1;
      drain();

      // data arrives before its instruction
      push_data(32'hD0);
      push_data(32'hD1);
      for (int i = 0; i < 5; i++) begin
         check("early_valid_low", 32'(store_op_valid), 32'd0);
         tick();
      end
      push_insn(4'd7, 8'd2);
      check("early_valid_high", 32'(store_op_valid), 32'd1);
      drain();

      // back-to-back completions including a zero-beat instruction
      gnt_cycles.delete();
      done_cycles.delete();
      push_data(32'h10);
      push_data(32'h20);
      push_insn(4'd1, 8'd1);
      push_insn(4'd2, 8'd0);
      push_insn(4'd4, 8'd1);
      drain();
      gnt_en = 1'b0;
      check("b2b_gnt_count", 32'(gnt_cycles.size()), 32'd2);
      check("b2b_done_count", 32'(done_cycles.size()), 32'd3);
      check("b2b_done_gap0", 32'(done_cycles[1] - done_cycles[0]), 32'd1);
      check("b2b_done_gap1", 32'(done_cycles[2] - done_cycles[1]), 32'd1);

      // flush in the middle of an instruction
      push_insn(4'd5, 8'd3);
      push_data(32'h51);
      push_data(32'h52);
      gnt_en = 1'b1;
      tick();
      gnt_en = 1'b0;
      do_flush();
      check("flush_done", 32'(done), 32'd0);
      check("flush_valid", 32'(store_op_valid), 32'd0);
      check("flush_insn_ready", 32'(insn_ready), 32'd1);
      check("flush_data_ready", 32'(data_ready), 32'd1);
      tick();
      check("flush_done_late", 32'(done), 32'd0);
      push_insn(4'd6, 8'd1);
      push_data(32'h61);
      gnt_en = 1'b1;
      drain();
      gnt_en = 1'b0;

      // last beat granted on the flush edge must not report completion
      push_insn(4'd11, 8'd1);
      push_data(32'h71);
      gnt_en = 1'b1;
      do_flush();
      check("flush_last_done", 32'(done), 32'd0);
      check("flush_last_valid", 32'(store_op_valid), 32'd0);
      tick();

      // asynchronous reset with queued beats
      push_insn(4'd9, 8'd2);
      push_data(32'h91);
      push_data(32'h92);
      #2 rst_n = 1'b0;
      #1;
      check("areset_valid", 32'(store_op_valid), 32'd0);
      check("areset_op", store_op, 32'd0);
      check("areset_done", 32'(done), 32'd0);
      exp_data.delete();
      exp_done.delete();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("post_rst_valid", 32'(store_op_valid), 32'd0);
         tick();
      end
      check("post_rst_data_ready", 32'(data_ready), 32'd1);
      push_insn(4'd10, 8'd1);
      push_data(32'hA1);
      gnt_en = 1'b1;
      drain();
      gnt_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/store_op_issuer.md
Name: store_op_issuer

Overview:
- Vector-core side transmitter of the store-operand stream: `store_op_valid_o` / `store_op_o` / `store_op_gnt_i`.
- Buffers VRF read data produced by the lane for store instructions and presents it beat by beat to the memory/scalar side.
- Tracks how many beats each store instruction owes.
- Reports completion (`done_o` + `insn_id`) once the last beat of an instruction has been granted.

Parameters:
- DataDepth, 4, number of entries in the data FIFO (power of two, ≥2).
- InsnDepth, 2, number of outstanding store instructions tracked (power of two, ≥2).
- BeatCntWidth, 8, width of the per-instruction beat counter.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  discard all buffered instructions and data
- insn_valid_i  input  1  new store instruction offered
- insn_ready_o  output  1  instruction queue not full
- insn_id_i  input  insn_id_t  id of offered instruction
- beat_cnt_i  input  BeatCntWidth  number of data beats the instruction will send
- data_valid_i  input  1  lane offers one VRF data beat
- data_ready_o  output  1  data FIFO not full
- data_i  input  vrf_data_t  data beat
- store_op_valid_o  output  1  beat available downstream
- store_op_o  output  vrf_data_t  current beat
- store_op_gnt_i  input  1  downstream accepts beat (asserted only while valid)
- done_o  output  1  one-cycle pulse: an instruction finished
- done_insn_id_o  output  insn_id_t  id of finished instruction

Behaviour:
- Reset (async, `rst_ni` low): both queues empty, pointers and counters zero. `store_op_valid_o`=0, `done_o`=0, `done_insn_id_o`=0, `store_op_o`=0. `insn_ready_o`=1 and `data_ready_o`=1 once reset is released. Reset mid-transfer drops everything with no done pulse.
- Instruction queue:
  - Pushes on `insn_valid_i && insn_ready_o`, storing `{id, beat_cnt_i}`.
  - `insn_ready_o` = !full, a function of registered state only.
  - A push while full is ignored.
- Data FIFO:
  - Pushes on `data_valid_i && data_ready_o`.
  - `data_ready_o` = !full, registered state only. There is no same-cycle pop-frees-slot pass-through.
  - No bypass: a beat pushed in cycle N is visible on `store_op_o` at N+1 at the earliest.
- Output:
  - `store_op_valid_o` = data FIFO non-empty AND instruction queue non-empty AND head remaining count ≠ 0.
  - `store_op_o` = data FIFO head entry (0 when empty).
  - Data stays stable while valid and not granted.
- Grant:
  - On `store_op_gnt_i && store_op_valid_o`: pop data FIFO and decrement the head remaining count.
  - If the count goes 1→0: pop the instruction queue in the same edge, and next cycle `done_o`=1 with `done_insn_id_o`=head id.
  - A `gnt` without valid is a protocol error and is ignored (verification asserts on it).
- Zero-beat instruction (`beat_cnt_i`=0):
  - Popped in the first cycle it is head, with `store_op_valid_o` held low.
  - `done_o` pulses the following cycle.
- Throughput: one beat per cycle. Back-to-back instructions may finish on consecutive cycles. At most one `done_o` per cycle.
- Simultaneous push and pop on either queue: both take effect, occupancy unchanged.
- Pointers wrap modulo depth. Occupancy counters are `$clog2(depth)+1` bits wide.
- Extra data beats beyond the sum of outstanding counts stay queued until a later instruction claims them.
- Flush:
  - Highest priority. On the edge where `flush_i`=1, empty both queues and ignore same-cycle pushes and grants.
  - `done_o` is forced to 0 the next cycle, even if a last beat was granted in the flush cycle.
  - `store_op_valid_o`=0 the cycle after flush.
- `done_o`, `done_insn_id_o` and the queue state are registered.
- `store_op_valid_o` and `store_op_o` are combinational from registered state only, with no path from `gnt`.

Test Plan:
- Basic: push insn id=3, beat_cnt=2; push data 0xA, 0xB; `gnt` held 1 → `store_op_o` 0xA then 0xB on consecutive cycles; `done_o`=1 with id=3 exactly one cycle after the 0xB grant.
- Backpressure: 4 data beats pushed with DataDepth=4 and `gnt`=0 → `data_ready_o`=0 and `store_op_o` stable at first beat. Release `gnt` for 1 cycle → `data_ready_o` returns to 1 the next cycle.
- Data before instruction: push 2 beats, no insn for 5 cycles → `store_op_valid_o`=0 throughout. Push id=7, cnt=2 → valid the next cycle, done id=7 after the second grant.
- Back-to-back: id=1 cnt=1, id=2 cnt=0, id=4 cnt=1 with data 0x10, 0x20, `gnt` always 1 → done pulses on consecutive cycles with ids 1, 2, 4, in order; no beat is emitted for id=2.
- Flush: id=5 cnt=3, one beat granted, then `flush_i`=1 → no `done_o`, `store_op_valid_o`=0, both readies 1 the next cycle. A following id=6 cnt=1 completes normally.
- Reset mid-operation: `rst_ni` pulled low with 2 queued beats → all outputs 0 immediately (async). After release, `store_op_valid_o`=0 until new insn and data are pushed.
